// File: rtl/apb_uart.sv
// APB3 UART: 8N1 with optional parity, 16x oversampled baud generator,
// single-entry TX/RX buffers and W1C interrupt status with per-source masks.
module apb_uart #(
    parameter logic [9:0] BASE_ADDR = 10'h000
) (
    input  logic        PCLK,
    input  logic        PCLKG,
    input  logic        PRESETn,
    input  logic        PSEL,
    input  logic [9:0]  PADDR,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PWDATA,
    input  logic [3:0]  ECOREVNUM,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    input  logic        clk_16m,
    input  logic        clk_16m_rstn,
    input  logic        RXD,
    output logic        TXD,
    output logic        TXEN,
    output logic        BAUDTICK,
    output logic        TXINT,
    output logic        RXINT,
    output logic        TXOVRINT,
    output logic        RXOVRINT,
    output logic        UARTINT,
    output logic        UARTINT_FLAG
);

    typedef enum logic [2:0] {
        TX_IDLE, TX_LOAD, TX_START, TX_DATA, TX_PAR, TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP
    } rx_state_t;

    logic        unused_pins;
    logic [9:0]  off;
    logic        in_blk, sel_rd, wr_en, rd_acc, wr_data, rx_rd;
    logic [6:0]  ctrl;
    logic [18:0] bauddiv;
    logic [1:0]  par_cfg;
    logic [14:0] baud_per, baud_cnt;
    logic        tick;
    logic [7:0]  tx_buf, tx_shift, rx_buf, rx_shift;
    logic        tx_full, rx_full, tx_par, rx_par_bit;
    logic [4:0]  int_stat, int_set, int_clr;
    tx_state_t   tx_state, tx_next;
    rx_state_t   rx_state, rx_next;
    logic [3:0]  tx_tick_cnt, rx_tick_cnt;
    logic [2:0]  tx_bit_idx, rx_bit_idx;
    logic        tx_load, tx_bit_end;
    logic        rx_done, rx_mid, rx_bit_end, rx_par_bad;
    logic        rxd_s1, rxd_s2, rxd_prev, rx_fall;

    assign unused_pins = &{1'b0, PCLKG, clk_16m, clk_16m_rstn, PWDATA[31:19]};

    // APB: PREADY is tied high so every access completes in its access phase;
    // writes commit on PSEL&PENABLE&PWRITE, reads are combinational while PSEL&!PWRITE.
    assign off     = PADDR - BASE_ADDR;
    assign in_blk  = (off < 10'd7);
    assign sel_rd  = PSEL & ~PWRITE & in_blk;
    assign wr_en   = PSEL & PENABLE & PWRITE & in_blk;
    assign rd_acc  = PSEL & PENABLE & ~PWRITE & in_blk;
    assign wr_data = wr_en && (off[2:0] == 3'd0);
    assign rx_rd   = rd_acc && (off[2:0] == 3'd0);
    assign int_clr = (wr_en && (off[2:0] == 3'd3)) ? PWDATA[4:0] : 5'd0;

    assign PREADY  = 1'b1;
    assign PSLVERR = 1'b0;
    assign TXEN    = ctrl[0];

    always_comb begin
        PRDATA = 32'd0;
        if (sel_rd) begin
            case (off[2:0])
                3'd0:    PRDATA = {24'd0, rx_buf};
                3'd1:    PRDATA = {27'd0, int_stat[4:2], rx_full, tx_full};
                3'd2:    PRDATA = {25'd0, ctrl};
                3'd3:    PRDATA = {27'd0, int_stat};
                3'd4:    PRDATA = {13'd0, bauddiv};
                3'd5:    PRDATA = {30'd0, par_cfg};
                3'd6:    PRDATA = {28'd0, ECOREVNUM};
                default: PRDATA = 32'd0;
            endcase
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            ctrl    <= '0;
            bauddiv <= '0;
            par_cfg <= '0;
        end else if (wr_en) begin
            case (off[2:0])
                3'd2:    ctrl    <= PWDATA[6:0];
                3'd4:    bauddiv <= PWDATA[18:0];
                3'd5:    par_cfg <= PWDATA[1:0];
                default: ;
            endcase
        end
    end

    // Tick period is BAUDDIV[18:4] cycles; a period of 1 ticks every cycle.
    assign baud_per = bauddiv[18:4];
    assign tick     = (baud_per != 15'd0) && (baud_cnt >= baud_per - 15'd1);
    assign BAUDTICK = tick;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)                        baud_cnt <= '0;
        else if (baud_per == 15'd0 || tick)  baud_cnt <= '0;
        else                                 baud_cnt <= baud_cnt + 15'd1;
    end

    // ---------------- transmitter ----------------
    assign tx_bit_end = tick && (tx_tick_cnt == 4'd15);

    always_comb begin
        tx_next = tx_state;
        tx_load = 1'b0;
        if (!ctrl[0]) begin
            tx_next = TX_IDLE;
        end else begin
            case (tx_state)
                TX_IDLE:  if (tx_full) begin tx_next = TX_LOAD; tx_load = 1'b1; end
                TX_LOAD:  if (tick) tx_next = TX_START;
                TX_START: if (tx_bit_end) tx_next = TX_DATA;
                TX_DATA:  if (tx_bit_end && tx_bit_idx == 3'd7)
                              tx_next = par_cfg[0] ? TX_PAR : TX_STOP;
                TX_PAR:   if (tx_bit_end) tx_next = TX_STOP;
                TX_STOP:  if (tx_bit_end) tx_next = TX_IDLE;
                default:  tx_next = TX_IDLE;
            endcase
        end
    end

    always_comb begin
        case (tx_state)
            TX_START: TXD = 1'b0;
            TX_DATA:  TXD = tx_shift[0];
            TX_PAR:   TXD = tx_par;
            default:  TXD = 1'b1;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            tx_state    <= TX_IDLE;
            tx_tick_cnt <= '0;
            tx_bit_idx  <= '0;
            tx_shift    <= '0;
            tx_par      <= 1'b0;
        end else begin
            tx_state <= tx_next;
            if (tx_state != tx_next) begin
                tx_tick_cnt <= '0;
                tx_bit_idx  <= '0;
            end else if (tick) begin
                tx_tick_cnt <= tx_tick_cnt + 4'd1;
            end
            if (tx_load) begin
                tx_shift <= tx_buf;
                tx_par   <= (^tx_buf) ^ par_cfg[1];
            end else if (tx_state == TX_DATA && tx_bit_end) begin
                tx_shift   <= {1'b0, tx_shift[7:1]};
                tx_bit_idx <= tx_bit_idx + 3'd1;
            end
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            tx_buf  <= '0;
            tx_full <= 1'b0;
        end else if (tx_load) begin
            tx_full <= 1'b0;
        end else if (wr_data && !tx_full) begin
            tx_buf  <= PWDATA[7:0];
            tx_full <= 1'b1;
        end
    end

    // ---------------- receiver ----------------
    // Synchronizer idles high so reset never looks like a start edge.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rxd_s1   <= 1'b1;
            rxd_s2   <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_s1   <= RXD;
            rxd_s2   <= rxd_s1;
            rxd_prev <= rxd_s2;
        end
    end

    assign rx_fall    = rxd_prev & ~rxd_s2;
    assign rx_mid     = tick && (rx_tick_cnt == 4'd7);
    assign rx_bit_end = tick && (rx_tick_cnt == 4'd15);
    assign rx_par_bad = par_cfg[0] && (rx_par_bit != ((^rx_shift) ^ par_cfg[1]));

    always_comb begin
        rx_next = rx_state;
        rx_done = 1'b0;
        if (!ctrl[1]) begin
            rx_next = RX_IDLE;
        end else begin
            case (rx_state)
                RX_IDLE:  if (rx_fall) rx_next = RX_START;
                RX_START: if (rx_mid && rxd_s2) rx_next = RX_IDLE;
                          else if (rx_bit_end) rx_next = RX_DATA;
                RX_DATA:  if (rx_bit_end && rx_bit_idx == 3'd7)
                              rx_next = par_cfg[0] ? RX_PAR : RX_STOP;
                RX_PAR:   if (rx_bit_end) rx_next = RX_STOP;
                RX_STOP:  if (rx_mid) begin rx_done = 1'b1; rx_next = RX_IDLE; end
                default:  rx_next = RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rx_state    <= RX_IDLE;
            rx_tick_cnt <= '0;
            rx_bit_idx  <= '0;
            rx_shift    <= '0;
            rx_par_bit  <= 1'b0;
        end else begin
            rx_state <= rx_next;
            if (rx_state != rx_next) begin
                rx_tick_cnt <= '0;
                rx_bit_idx  <= '0;
            end else if (tick) begin
                rx_tick_cnt <= rx_tick_cnt + 4'd1;
                if (rx_state == RX_DATA && rx_tick_cnt == 4'd15)
                    rx_bit_idx <= rx_bit_idx + 3'd1;
            end
            if (rx_state == RX_DATA && rx_mid) rx_shift   <= {rxd_s2, rx_shift[7:1]};
            if (rx_state == RX_PAR && rx_mid)  rx_par_bit <= rxd_s2;
        end
    end

    // A byte arriving while the buffer is still full is dropped; the old byte stays.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rx_buf  <= '0;
            rx_full <= 1'b0;
        end else if (rx_done && !rx_full) begin
            rx_buf  <= rx_shift;
            rx_full <= 1'b1;
        end else if (rx_rd) begin
            rx_full <= 1'b0;
        end
    end

    // ---------------- interrupts ----------------
    assign int_set = {rx_done & rx_par_bad, rx_done & rx_full,
                      wr_data & tx_full, rx_done & ~rx_full, tx_load};

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) int_stat <= '0;
        else          int_stat <= (int_stat & ~int_clr) | int_set;
    end

    assign TXINT        = int_stat[0] & ctrl[2];
    assign RXINT        = int_stat[1] & ctrl[3];
    assign TXOVRINT     = int_stat[2] & ctrl[4];
    assign RXOVRINT     = int_stat[3] & ctrl[5];
    assign UARTINT      = TXINT | RXINT | TXOVRINT | RXOVRINT | (int_stat[4] & ctrl[6]);
    assign UARTINT_FLAG = |int_stat;

endmodule

// File: tb/tb_apb_uart.sv
// Directed bench for two cross-wired apb_uart instances at word bases 0x000 and 0x008.
module tb_apb_uart;

    logic        PCLK = 1'b0;
    logic        PRESETn, PSEL, PENABLE, PWRITE;
    logic [9:0]  PADDR;
    logic [31:0] PWDATA;
    logic [3:0]  ECOREVNUM;
    logic [31:0] prdata0, prdata1;
    logic [1:0]  txd, txen, baudtick, txint, rxint, txovrint, rxovrint;
    logic [1:0]  uartint, uartint_flag, pready, pslverr;

    int          vec_cnt = 0;
    int          err_cnt = 0;
    int          cyc = 0;
    int          wr_start = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  exp_q_u0[$];
    logic [31:0] d0, d1;

    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc <= cyc + 1;

    apb_uart #(.BASE_ADDR(10'h000)) u0 (
        .PCLK(PCLK), .PCLKG(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PADDR(PADDR),
        .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA), .ECOREVNUM(ECOREVNUM),
        .PRDATA(prdata0), .PREADY(pready[0]), .PSLVERR(pslverr[0]), .clk_16m(PCLK),
        .clk_16m_rstn(PRESETn), .RXD(txd[1]), .TXD(txd[0]), .TXEN(txen[0]),
        .BAUDTICK(baudtick[0]), .TXINT(txint[0]), .RXINT(rxint[0]),
        .TXOVRINT(txovrint[0]), .RXOVRINT(rxovrint[0]), .UARTINT(uartint[0]),
        .UARTINT_FLAG(uartint_flag[0])
    );

    apb_uart #(.BASE_ADDR(10'h008)) u1 (
        .PCLK(PCLK), .PCLKG(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PADDR(PADDR),
        .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA), .ECOREVNUM(ECOREVNUM),
        .PRDATA(prdata1), .PREADY(pready[1]), .PSLVERR(pslverr[1]), .clk_16m(PCLK),
        .clk_16m_rstn(PRESETn), .RXD(txd[0]), .TXD(txd[1]), .TXEN(txen[1]),
        .BAUDTICK(baudtick[1]), .TXINT(txint[1]), .RXINT(rxint[1]),
        .TXOVRINT(txovrint[1]), .RXOVRINT(rxovrint[1]), .UARTINT(uartint[1]),
        .UARTINT_FLAG(uartint_flag[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_val);
        vec_cnt++;
        if (obs !== exp_val) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp_val);
        end
    endtask

    task automatic apb_write(input logic [9:0] addr, input logic [31:0] data);
        @(negedge PCLK);
        wr_start = cyc;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = data;
        @(negedge PCLK);
        PENABLE = 1'b1;
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [9:0] addr, output logic [31:0] r0, output logic [31:0] r1);
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr;
        @(negedge PCLK);
        PENABLE = 1'b1;
        #1;
        r0 = prdata0;
        r1 = prdata1;
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    // Reads the DATA register of one instance and scores it against that receiver's queue.
    task automatic check_rx(input string tag, input bit inst);
        logic [31:0] r0, r1, obs, want;
        apb_read(inst ? 10'h008 : 10'h000, r0, r1);
        obs = inst ? r1 : r0;
        want = 'x;
        if (inst && exp_q.size() > 0)       want = {24'd0, exp_q.pop_front()};
        else if (!inst && exp_q_u0.size() > 0) want = {24'd0, exp_q_u0.pop_front()};
        check(tag, obs, want);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge PCLK);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, lat0, lat1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
        ECOREVNUM = 4'h0; PRESETn = 1'b0;
        idle(3);
        check("rst_txd", {30'd0, txd}, 32'h3);
        check("rst_uartint", {30'd0, uartint}, 32'h0);
        check("rst_baudtick", {30'd0, baudtick}, 32'h0);
        check("rst_pready", {30'd0, pready}, 32'h3);
        check("rst_pslverr", {30'd0, pslverr}, 32'h0);
        PRESETn = 1'b1;
        for (int a = 0; a < 16; a++) begin
            apb_read(a[9:0], d0, d1);
            check($sformatf("rst_rd_u0_%0d", a), d0, 32'h0);
            check($sformatf("rst_rd_u1_%0d", a), d1, 32'h0);
        end

        // Revision number readable at ID only from the addressed block.
        ECOREVNUM = 4'hA;
        apb_read(10'h006, d0, d1);
        check("id_u0", d0, 32'hA);
        check("id_u0_other", d1, 32'h0);
        apb_read(10'h00E, d0, d1);
        check("id_u1", d1, 32'hA);
        check("id_u1_other", d0, 32'h0);

        // Cross transfer: 0x12 from u0 to u1, 0xAB from u1 to u0.
        apb_write(10'h004, 32'h10);
        apb_write(10'h00C, 32'h10);
        apb_write(10'h002, 32'h3F);
        apb_write(10'h00A, 32'h3F);
        apb_read(10'h002, d0, d1);
        check("ctrl_u0", d0, 32'h3F);
        apb_read(10'h00C, d0, d1);
        check("bauddiv_u1", d1, 32'h10);
        check("baudtick_on", {30'd0, baudtick}, 32'h3);
        check("txen_on", {30'd0, txen}, 32'h3);
        apb_write(10'h000, 32'h12);
        t0 = wr_start;
        exp_q.push_back(8'h12);
        apb_write(10'h008, 32'hAB);
        t1 = wr_start;
        exp_q_u0.push_back(8'hAB);
        lat0 = -1;
        lat1 = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge PCLK);
            if (rxint[1] && lat1 < 0) lat1 = cyc - t0;
            if (rxint[0] && lat0 < 0) lat0 = cyc - t1;
        end
        check("lat_u1_158_162", {31'd0, (lat1 >= 158 && lat1 <= 162)}, 32'h1);
        check("lat_u0_158_162", {31'd0, (lat0 >= 158 && lat0 <= 162)}, 32'h1);
        check("rxint_both", {30'd0, rxint}, 32'h3);
        check("txint_both", {30'd0, txint}, 32'h3);
        apb_read(10'h009, d0, d1);
        check("status_u1_rxfull", d1, 32'h2);
        check_rx("data_u1", 1'b1);
        check_rx("data_u0", 1'b0);
        apb_read(10'h009, d0, d1);
        check("status_u1_read_clr", d1, 32'h0);
        apb_write(10'h003, 32'h1F);
        apb_write(10'h00B, 32'h1F);
        check("uartint_clr1", {30'd0, uartint}, 32'h0);

        // TX overrun on u0; the two accepted bytes overrun u1's receiver.
        apb_write(10'h000, 32'h34);
        exp_q.push_back(8'h34);
        apb_write(10'h000, 32'h56);
        apb_write(10'h000, 32'h78);
        apb_read(10'h001, d0, d1);
        check("status_u0_txovr", d0, 32'h5);
        check("txovrint_u0", {31'd0, txovrint[0]}, 32'h1);
        idle(450);
        apb_read(10'h009, d0, d1);
        check("status_u1_rxovr", d1, 32'hA);
        check("rxovrint_u1", {31'd0, rxovrint[1]}, 32'h1);
        check_rx("data_u1_kept", 1'b1);
        apb_write(10'h003, 32'hF);
        apb_read(10'h003, d0, d1);
        check("int_u0_w1c", d0, 32'h0);
        check("uartint_u0_w1c", {31'd0, uartint[0]}, 32'h0);
        apb_write(10'h00B, 32'hF);
        apb_read(10'h00B, d0, d1);
        check("int_u1_w1c", d1, 32'h0);
        check("uartint_u1_w1c", {31'd0, uartint[1]}, 32'h0);
        apb_read(10'h009, d0, d1);
        check("status_u1_ovr_clr", d1, 32'h0);

        // Parity: even on u0 TX, odd on u1 RX -> error; both even -> clean.
        apb_write(10'h005, 32'h1);
        apb_write(10'h00D, 32'h3);
        apb_write(10'h000, 32'h01);
        exp_q.push_back(8'h01);
        idle(400);
        apb_read(10'h00B, d0, d1);
        check("int_u1_parerr", d1, 32'h12);
        check("flag_u1_parerr", {31'd0, uartint_flag[1]}, 32'h1);
        check_rx("data_u1_par1", 1'b1);
        apb_write(10'h003, 32'h1F);
        apb_write(10'h00B, 32'h1F);
        apb_write(10'h00D, 32'h1);
        apb_write(10'h000, 32'h01);
        exp_q.push_back(8'h01);
        idle(400);
        apb_read(10'h00B, d0, d1);
        check("int_u1_parok", d1, 32'h02);
        check_rx("data_u1_par2", 1'b1);

        // Address isolation between the two blocks.
        apb_write(10'h00A, 32'h03);
        apb_read(10'h002, d0, d1);
        check("iso_ctrl_u0", d0, 32'h3F);
        check("iso_other_u1", d1, 32'h0);
        apb_read(10'h00A, d0, d1);
        check("iso_ctrl_u1", d1, 32'h03);
        check("iso_other_u0", d0, 32'h0);
        apb_write(10'h00A, 32'h02);
        check("txen_u1_off", {30'd0, txen}, 32'h1);
        check("txd_u1_idle", {31'd0, txd[1]}, 32'h1);

        check("exp_q_drained", exp_q.size(), 32'h0);
        check("exp_q_u0_drained", exp_q_u0.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/apb_uart.md
# apb_uart

APB3-attached 8-bit UART with a 16× oversampled baud generator, single-entry TX/RX buffers, optional parity and per-source interrupts. Several instances share one APB select and are told apart by a word-address base parameter; the two system UARTs sit at word bases 0x000 and 0x008 and are cross-wired TXD↔RXD.

## Interface
- BASE_ADDR, 10'h000, word base of the register block within PADDR[11:2] (second UART: 10'h008)
- PCLK  in  1  sole clock; all logic on its rising edge
- PRESETn  in  1  asynchronous active-low reset
- PCLKG, clk_16m  in  1  pin-compatibility inputs, driven from PCLK, unused internally
- clk_16m_rstn  in  1  pin-compatibility input, unused; PRESETn is the only reset
- PSEL, PENABLE, PWRITE  in  1  APB control
- PADDR  in  10 [11:2]  word address
- PWDATA  in  32  write data
- ECOREVNUM  in  4  revision number, readable
- PRDATA  out  32  read data, 0 when not addressed
- PREADY  out  1  constant 1; PSLVERR  out  1  constant 0
- RXD  in  1  serial in; TXD  out  1  serial out, idle 1
- TXEN  out  1  = CTRL[0]
- BAUDTICK  out  1  one-cycle 16× oversample tick
- TXINT, RXINT, TXOVRINT, RXOVRINT  out  1  masked interrupts
- UARTINT  out  1  OR of masked interrupts; UARTINT_FLAG  out  1  OR of raw INT status bits

## Operation
- Register hit: PADDR == BASE_ADDR + offset. Write on PSEL&PENABLE&PWRITE edge; read is combinational when PSEL&!PWRITE.
- 0x0 DATA: write [7:0] → TX buffer; read [7:0] = RX buffer, clears RX-full.
- 0x1 STATUS (RO): [0] TX full, [1] RX full, [2] TX overrun, [3] RX overrun, [4] parity error.
- 0x2 CTRL [6:0]: [0] TX en, [1] RX en, [2] TX int en, [3] RX int en, [4] TX ovr int en, [5] RX ovr int en, [6] parity-error int en.
- 0x3 INT [4:0] (W1C): [0] TX, [1] RX, [2] TX ovr, [3] RX ovr, [4] parity; bits 2–4 mirror STATUS[2..4] and clear both.
- 0x4 BAUDDIV [18:0]: tick period = BAUDDIV[18:4] PCLK cycles; 0 stops generator. Bit period = 16 ticks.
- 0x5 PARITY [1:0]: [0] enable, [1] odd(1)/even(0).
- 0x6 ID: [3:0] = ECOREVNUM. Other offsets read 0, writes ignored.
- Frame: start 0, D0..D7 LSB first, parity bit if enabled, one stop 1.
- TX: write with TX full sets TX ovr, data dropped. When shifter idle and buffer full (and TX en), buffer→shifter, TX full clears, INT[0] sets. TXD=1 when idle or TX disabled.
- RX (RX en): RXD through 2-flop synchronizer; falling edge starts count; start re-checked at tick 8, abort if high; each bit sampled at its tick 8. After stop sample: RX full was set → RX ovr (old byte kept); else store, set RX full and INT[1]; parity mismatch sets INT[4].
- INT bits set on event regardless of enable; TXINT=INT[0]&CTRL[2], etc.; W1C and new event same cycle → stays set.

## Timing
- Reset: all registers 0, TXD=1, all interrupt outputs 0, BAUDTICK=0, PREADY=1, PSLVERR=0.
- Write visible on register outputs the cycle after access-phase edge.
- Buffer→shifter 1 cycle after write when idle; start bit begins at next BAUDTICK.
- BAUDDIV=16: tick every cycle, 16 cycles/bit, 160 cycles/frame (no parity).
- RX full and INT[1] assert 1 cycle after stop-bit mid sample.
- Disabling TX/RX mid-frame aborts shifter to idle; buffers unchanged.

## Test plan
- Reset → STATUS=0, TXD=1, UARTINT=0, PRDATA=0 at every offset.
- Both instances: DATA=0x12/0xAB, CTRL=0x3F, BAUDDIV=0x10 → each receives other's byte in 160±2 cycles; DATA reads 0x12/0xAB; RXINT=1.
- Write DATA twice while TX busy, third before buffer drains → STATUS[2]=1, TXOVRINT=1; write INT=0xF → all INT bits 0, UARTINT=0.
- Send 0x34 then 0x56 without reading RX → RX ovr set, DATA still 0x34.
- PARITY=0x1 on TX, 0x3 on RX, send 0x01 → INT[4]=1; same setting both → INT[4]=0.
- Write at BASE 0x008 → BASE 0x000 registers unchanged; reads of other block return 0.
